// File: rtl/m_seq_src_if.sv
// m_seq_src_if: registered output stream of the sequence source.
// master drives data/valid/last and samples ready; slave is the consumer.
interface m_seq_src_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] m_seq_src_out_data;
  logic              m_seq_src_out_valid;
  logic              m_seq_src_out_ready;
  logic              m_seq_src_out_last;

  modport master (
    output m_seq_src_out_data,
    output m_seq_src_out_valid,
    output m_seq_src_out_last,
    input  m_seq_src_out_ready
  );

  modport slave (
    input  m_seq_src_out_data,
    input  m_seq_src_out_valid,
    input  m_seq_src_out_last,
    output m_seq_src_out_ready
  );
endinterface

// File: rtl/m_seq_src.sv
// m_seq_src: sequence source (constant, all-ones, up/down ramp) on a
// registered valid/ready stream. Ports: clk, async active-low reset,
// sync init, in_disable stall, cfg_* (sampled at launch), start pulse,
// m_seq_src_out stream (data/valid/ready/last), busy, done pulse.
// Macro M_SEQ_SRC_SAT_EN: ramps clamp at all-ones / zero instead of wrapping.
module m_seq_src #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              m_seq_src_clk,
  input  logic              m_seq_src_reset,
  input  logic              m_seq_src_init,
  input  logic              m_seq_src_in_disable,
  input  logic [1:0]        m_seq_src_cfg_mode,
  input  logic [DATA_W-1:0] m_seq_src_cfg_start,
  input  logic [DATA_W-1:0] m_seq_src_cfg_stride,
  input  logic [CNT_W-1:0]  m_seq_src_cfg_len,
  input  logic              m_seq_src_start,
  m_seq_src_if.master       m_seq_src_out,
  output logic              m_seq_src_busy,
  output logic              m_seq_src_done
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  typedef enum logic [1:0] {
    M_CONST,
    M_UP,
    M_DOWN,
    M_ONES
  } mode_t;

  state_t            state, state_n;
  mode_t             mode, mode_n;
  logic [DATA_W-1:0] stride, stride_n;
  logic [CNT_W-1:0]  len, len_n;
  logic [CNT_W-1:0]  count, count_n;
  logic [DATA_W-1:0] data, data_n;
  logic              valid, valid_n;
  logic              last, last_n;
  logic              busy, busy_n;
  logic              done, done_n;

  logic              xfer;
  logic [DATA_W-1:0] up_val;
  logic [DATA_W-1:0] dn_val;
  logic [CNT_W-1:0]  cnt_inc;

  assign xfer = valid
              & m_seq_src_out.m_seq_src_out_ready
              & ~m_seq_src_in_disable;

  assign cnt_inc = count + CNT_W'(1);

`ifdef M_SEQ_SRC_SAT_EN
  logic [DATA_W:0] up_sum;
  assign up_sum = {1'b0, data} + {1'b0, stride};
  assign up_val = up_sum[DATA_W] ? '1 : up_sum[DATA_W-1:0];
  assign dn_val = (stride > data) ? '0 : data - stride;
`else
  assign up_val = data + stride;
  assign dn_val = data - stride;
`endif

  always_comb begin
    state_n  = state;
    mode_n   = mode;
    stride_n = stride;
    len_n    = len;
    count_n  = count;
    data_n   = data;
    valid_n  = valid;
    last_n   = last;
    busy_n   = busy;
    done_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (m_seq_src_start) begin
          mode_n   = mode_t'(m_seq_src_cfg_mode);
          stride_n = m_seq_src_cfg_stride;
          len_n    = m_seq_src_cfg_len;
          count_n  = '0;
          data_n   = (mode_t'(m_seq_src_cfg_mode) == M_ONES)
                   ? '1 : m_seq_src_cfg_start;
          valid_n  = 1'b1;
          busy_n   = 1'b1;
          last_n   = (m_seq_src_cfg_len == CNT_W'(1));
          state_n  = RUN;
        end
      end
      RUN: begin
        if (xfer) begin
          if (last) begin
            valid_n = 1'b0;
            last_n  = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            count_n = cnt_inc;
            unique case (mode)
              M_UP:    data_n = up_val;
              M_DOWN:  data_n = dn_val;
              default: data_n = data;
            endcase
            // len=0 is endless: never flag last even when count hits all-ones
            last_n = (len != '0) && (cnt_inc == len - CNT_W'(1));
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge m_seq_src_clk or negedge m_seq_src_reset) begin
    if (!m_seq_src_reset) begin
      state  <= IDLE;
      mode   <= M_CONST;
      stride <= '0;
      len    <= '0;
      count  <= '0;
      data   <= '0;
      valid  <= 1'b0;
      last   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (m_seq_src_init) begin
      state  <= IDLE;
      mode   <= M_CONST;
      stride <= '0;
      len    <= '0;
      count  <= '0;
      data   <= '0;
      valid  <= 1'b0;
      last   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      mode   <= mode_n;
      stride <= stride_n;
      len    <= len_n;
      count  <= count_n;
      data   <= data_n;
      valid  <= valid_n;
      last   <= last_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

  assign m_seq_src_out.m_seq_src_out_data  = data;
  assign m_seq_src_out.m_seq_src_out_valid = valid;
  assign m_seq_src_out.m_seq_src_out_last  = last;
  assign m_seq_src_busy = busy;
  assign m_seq_src_done = done;

endmodule

// File: doc/m_seq_src.md
# m_seq_src

Parametrised sequence source: the next generation of the fixed-constant generator. Emits either a programmable constant, the legacy all-ones word, or an up/down ramp of programmable start, stride and length. Output is a registered valid/ready stream feeding datapath operands. Stalls are driven by `in_disable` and downstream back-pressure.

## Interface

Parameters:
- `DATA_W`, 32: output word width (≥ 2).
- `CNT_W`, 16: length counter width.

Ports:
- `m_seq_src_clk`  in  1  sole clock; all logic on the rising edge.
- `m_seq_src_reset`  in  1  asynchronous, active-low reset.
- `m_seq_src_init`  in  1  synchronous restart; same effect as reset.
- `m_seq_src_in_disable`  in  1  when 1, no transfer and no state advance.
- `m_seq_src_cfg_mode`  in  2  0=CONST, 1=RAMP_UP, 2=RAMP_DOWN, 3=ONES.
- `m_seq_src_cfg_start`  in  DATA_W  first or constant value.
- `m_seq_src_cfg_stride`  in  DATA_W  ramp increment, unsigned.
- `m_seq_src_cfg_len`  in  CNT_W  element count; 0 = endless.
- `m_seq_src_start`  in  1  single-cycle launch pulse.
- `m_seq_src_out_data`  out  DATA_W  current element, registered.
- `m_seq_src_out_valid`  out  1  element available.
- `m_seq_src_out_ready`  in  1  consumer accepts.
- `m_seq_src_out_last`  out  1  current element is element len-1.
- `m_seq_src_busy`  out  1  FSM in RUN.
- `m_seq_src_done`  out  1  one-cycle pulse after last transfer.

## Operation

- FSM states: IDLE, RUN.
- Reset or init: state IDLE. `out_data`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0, count=0.
- IDLE:
  - On `start`=1, latch mode, start, stride and len.
  - Load `out_data`: ONES gives all ones; every other mode gives `cfg_start`.
  - Set `out_valid`=1 and `busy`=1. Set `out_last` = (len==1). Go to RUN.
- Transfer occurs when `out_valid & out_ready & ~in_disable`.
- On each transfer in RUN:
  - count += 1.
  - CONST/ONES: data unchanged.
  - RAMP_UP: data += stride. RAMP_DOWN: data −= stride.
  - Arithmetic is DATA_W-bit modulo (see Configuration).
  - `out_last` = (count_next == len−1).
- Transfer with `out_last`=1 (len≠0):
  - Clear `out_valid`, `out_last` and `busy`. Go to IDLE.
  - Pulse `done` for one cycle. `out_data` holds its last value.
- len=0: endless stream, `out_last` never asserts, count wraps silently. Only init or reset ends it.
- Without a transfer, `out_data`, `out_valid` and `out_last` hold. `in_disable` does not drop `out_valid`.
- `start` in RUN is ignored; cfg inputs are sampled only at launch.
- Priority: reset > init > start/transfer. Init mid-stream aborts with no `done` pulse.

## Timing

- Launch latency: `start` sampled at edge N gives `out_valid`=1 and first data after edge N.
- Throughput: one element per cycle while `out_ready`=1 and `in_disable`=0.
- `done` is high the cycle after the final transfer edge, coincident with `busy`=0.
- The earliest relaunch is `start` in the same cycle as `done`.
- `out_ready` may toggle freely; data is stable while valid and not accepted.
- No combinational path from any input to any output.

## Configuration

- Macro: `M_SEQ_SRC_SAT_EN`.
- Defined:
  - RAMP_UP clamps at 2^DATA_W−1; RAMP_DOWN clamps at 0.
  - Once clamped, the value repeats until the stream ends.
- Undefined:
  - Ramps wrap modulo 2^DATA_W.
  - No clamp comparators are synthesised.

## Test plan

- ONES, len=3, ready=1: after start, data=0xFFFFFFFF for 3 cycles; last on the 3rd; `done` one cycle later.
- RAMP_UP, start=10, stride=5, len=4, ready held low 2 cycles mid-stream: data 10,15,20,25 with no loss and no duplication; data held during the stall.
- RAMP_UP, start=0xFFFFFFF0, stride=0x10, len=3: values FFFFFFF0, 0, 10 without the macro; FFFFFFF0, FFFFFFFF, FFFFFFFF with `M_SEQ_SRC_SAT_EN`.
- RAMP_DOWN, start=4, stride=3, len=3, `in_disable` high for 2 cycles: 4,1,0xFFFFFFFE (wrap); no transfer while disabled; valid stays 1.
- CONST 0x1234, len=0, 100 transfers, then init: 0x1234 continuously with no last and no done; after init valid=0, busy=0.
- Reset asserted mid-RAMP: all outputs 0 immediately (async); start one cycle after release relaunches from cfg_start.
